// File: rtl/riscv_mem_arbiter_pkg.sv
// Shared definitions for the two-requester DRAM port arbiter: bus widths,
// tag split, beat counts and the muxed request record.
package riscv_mem_arbiter_pkg;

  localparam int MEM_ADDR_BITS = 26;
  localparam int MEM_DATA_BITS = 128;
  localparam int MEM_TAG_BITS  = 6;

  localparam int N_REQ_DEF    = 2;
  localparam int WR_BEATS_DEF = 2;
  localparam int RD_BEATS_DEF = 2;
  localparam int MAX_OUT_DEF  = 8;

  // Counter widths must stay at least one bit even for single-beat setups.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int ID_BITS_DEF   = clog2_min1(N_REQ_DEF);
  localparam int CTAG_BITS_DEF = MEM_TAG_BITS - ID_BITS_DEF;

  typedef struct packed {
    logic                     rw;
    logic [MEM_ADDR_BITS-1:0] addr;
    logic [MEM_DATA_BITS-1:0] data;
    logic [MEM_TAG_BITS-1:0]  tag;
  } mem_req_t;

  typedef enum logic {
    ST_OPEN   = 1'b0,
    ST_LOCKED = 1'b1
  } lock_state_t;

endpackage

// File: rtl/riscv_mem_arbiter_if.sv
// Requester-side and memory-side bundles of the DRAM port arbiter.
// The arbiter is the slave of the requester bundle and the master of the memory bundle.
interface riscv_mem_arbiter_if
  import riscv_mem_arbiter_pkg::*;
#(
  parameter int N_REQ     = N_REQ_DEF,
  parameter int CTAG_BITS = CTAG_BITS_DEF
);
  logic [N_REQ-1:0]                    req_val;
  logic [N_REQ-1:0]                    req_rdy;
  logic [N_REQ-1:0]                    req_rw;
  logic [N_REQ-1:0][MEM_ADDR_BITS-1:0] req_addr;
  logic [N_REQ-1:0][MEM_DATA_BITS-1:0] req_data;
  logic [N_REQ-1:0][CTAG_BITS-1:0]     req_tag;
  logic [N_REQ-1:0]                    resp_val;
  logic [MEM_DATA_BITS-1:0]            resp_data;
  logic [CTAG_BITS-1:0]                resp_tag;

  modport master (
    output req_val, req_rw, req_addr, req_data, req_tag,
    input  req_rdy, resp_val, resp_data, resp_tag
  );

  modport slave (
    input  req_val, req_rw, req_addr, req_data, req_tag,
    output req_rdy, resp_val, resp_data, resp_tag
  );
endinterface

interface riscv_mem_arbiter_mem_if
  import riscv_mem_arbiter_pkg::*;
;
  logic                     mem_req_val;
  logic                     mem_req_rdy;
  logic                     mem_req_rw;
  logic [MEM_ADDR_BITS-1:0] mem_req_addr;
  logic [MEM_DATA_BITS-1:0] mem_req_data;
  logic [MEM_TAG_BITS-1:0]  mem_req_tag;
  logic                     mem_resp_val;
  logic [MEM_DATA_BITS-1:0] mem_resp_data;
  logic [MEM_TAG_BITS-1:0]  mem_resp_tag;

  modport master (
    output mem_req_val, mem_req_rw, mem_req_addr, mem_req_data, mem_req_tag,
    input  mem_req_rdy, mem_resp_val, mem_resp_data, mem_resp_tag
  );

  modport slave (
    input  mem_req_val, mem_req_rw, mem_req_addr, mem_req_data, mem_req_tag,
    output mem_req_rdy, mem_resp_val, mem_resp_data, mem_resp_tag
  );
endinterface

// File: rtl/riscv_mem_arbiter_rr_arbiter.sv
// N-way round-robin picker: first request at or above i_ptr (with wrap), or
// only i_lock_id while a write burst holds the lock.
module rr_arbiter #(
  parameter int N   = 2,
  parameter int IDW = $clog2(N)
) (
  input  logic [N-1:0]   i_req,
  input  logic [IDW-1:0] i_ptr,
  input  logic           i_lock,
  input  logic [IDW-1:0] i_lock_id,
  output logic [N-1:0]   o_grant,
  output logic [IDW-1:0] o_grant_id
);

  logic [IDW-1:0] w_idx;

  always_comb begin
    o_grant    = '0;
    o_grant_id = i_ptr;
    w_idx      = '0;
    if (i_lock) begin
      o_grant_id         = i_lock_id;
      o_grant[i_lock_id] = i_req[i_lock_id];
    end else begin
      // Walk from the farthest offset down so the nearest hit to i_ptr wins.
      for (int k = N - 1; k >= 0; k--) begin
        w_idx = i_ptr + IDW'(k);
        if (i_req[w_idx]) begin
          o_grant        = '0;
          o_grant[w_idx] = 1'b1;
          o_grant_id     = w_idx;
        end
      end
    end
  end

endmodule

// File: rtl/riscv_mem_arbiter.sv
// Shares the DRAM adapter port between cache refill requesters: round-robin
// grant, write-burst lock, per-requester read credit, tag-routed responses.
module riscv_mem_arbiter
  import riscv_mem_arbiter_pkg::*;
#(
  parameter int N_REQ     = N_REQ_DEF,
  parameter int ID_BITS   = $clog2(N_REQ),
  parameter int CTAG_BITS = MEM_TAG_BITS - ID_BITS,
  parameter int WR_BEATS  = WR_BEATS_DEF,
  parameter int RD_BEATS  = RD_BEATS_DEF,
  parameter int MAX_OUT   = MAX_OUT_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  riscv_mem_arbiter_if.slave      req_bus,
  riscv_mem_arbiter_mem_if.master mem_bus
);

  localparam int CNT_W = $clog2(MAX_OUT + 1);
  localparam int WB_W  = clog2_min1(WR_BEATS);
  localparam int RB_W  = clog2_min1(RD_BEATS);

  lock_state_t                  r_state, w_state_nxt;
  logic [ID_BITS-1:0]           r_lock_id, w_lock_id_nxt;
  logic [WB_W-1:0]              r_wbeat, w_wbeat_nxt;
  logic [ID_BITS-1:0]           r_rr_ptr;
  logic [RB_W-1:0]              r_rbeat;
  logic [N_REQ-1:0][CNT_W-1:0]  r_out_cnt;

  logic [N_REQ-1:0]   w_elig;
  logic [N_REQ-1:0]   w_cand;
  logic [N_REQ-1:0]   w_grant;
  logic [ID_BITS-1:0] w_grant_id;
  mem_req_t           w_req;
  logic               w_req_val;
  logic               w_accept;
  logic               w_wr_last;
  logic               w_xact_done;
  logic [ID_BITS-1:0] w_resp_id;
  logic               w_resp_last;
  logic [N_REQ-1:0]   w_inc;
  logic [N_REQ-1:0]   w_dec;

  // While locked only the lock owner's write beats are candidates; a read from
  // it (or anything from the others) stalls the port until the burst resumes.
  always_comb begin
    w_elig = '0;
    w_cand = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_elig[i] = req_bus.req_val[i] &
                  (req_bus.req_rw[i] | (r_out_cnt[i] < CNT_W'(MAX_OUT)));
      w_cand[i] = w_elig[i] & ((r_state == ST_OPEN) | req_bus.req_rw[i]);
    end
  end

  rr_arbiter #(
    .N   (N_REQ),
    .IDW (ID_BITS)
  ) u_rr (
    .i_req      (w_cand),
    .i_ptr      (r_rr_ptr),
    .i_lock     (r_state == ST_LOCKED),
    .i_lock_id  (r_lock_id),
    .o_grant    (w_grant),
    .o_grant_id (w_grant_id)
  );

  always_comb begin
    w_req.rw   = req_bus.req_rw[w_grant_id];
    w_req.addr = req_bus.req_addr[w_grant_id];
    w_req.data = req_bus.req_data[w_grant_id];
    w_req.tag  = {w_grant_id, req_bus.req_tag[w_grant_id]};
  end

  assign w_req_val = (|w_grant) & reset;
  assign w_accept  = w_req_val & mem_bus.mem_req_rdy;

  assign mem_bus.mem_req_val  = w_req_val;
  assign mem_bus.mem_req_rw   = w_req.rw;
  assign mem_bus.mem_req_addr = w_req.addr;
  assign mem_bus.mem_req_data = w_req.data;
  assign mem_bus.mem_req_tag  = w_req.tag;

  assign req_bus.req_rdy = w_grant & {N_REQ{mem_bus.mem_req_rdy & reset}};

  assign w_wr_last   = (r_state == ST_LOCKED) ? (r_wbeat == WB_W'(WR_BEATS - 1))
                                              : (WR_BEATS == 1);
  assign w_xact_done = w_accept & (~w_req.rw | w_wr_last);

  always_comb begin
    w_state_nxt   = r_state;
    w_lock_id_nxt = r_lock_id;
    w_wbeat_nxt   = r_wbeat;
    unique case (r_state)
      ST_OPEN: begin
        if (w_accept && w_req.rw && (WR_BEATS > 1)) begin
          w_state_nxt   = ST_LOCKED;
          w_lock_id_nxt = w_grant_id;
          w_wbeat_nxt   = WB_W'(1);
        end
      end
      ST_LOCKED: begin
        if (w_accept) begin
          if (w_wr_last) begin
            w_state_nxt = ST_OPEN;
            w_wbeat_nxt = '0;
          end else begin
            w_wbeat_nxt = r_wbeat + WB_W'(1);
          end
        end
      end
      default: w_state_nxt = ST_OPEN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_OPEN;
      r_lock_id <= '0;
      r_wbeat   <= '0;
      r_rr_ptr  <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_lock_id <= w_lock_id_nxt;
      r_wbeat   <= w_wbeat_nxt;
      if (w_xact_done) r_rr_ptr <= w_grant_id + ID_BITS'(1);
    end
  end

  // Responses arrive in order, unbroken, and cannot be stalled.
  assign w_resp_id   = mem_bus.mem_resp_tag[MEM_TAG_BITS-1 -: ID_BITS];
  assign w_resp_last = mem_bus.mem_resp_val & (r_rbeat == RB_W'(RD_BEATS - 1));

  always_comb begin
    req_bus.resp_val = '0;
    for (int i = 0; i < N_REQ; i++) begin
      req_bus.resp_val[i] = mem_bus.mem_resp_val & reset & (w_resp_id == ID_BITS'(i));
    end
  end

  assign req_bus.resp_data = mem_bus.mem_resp_data;
  assign req_bus.resp_tag  = mem_bus.mem_resp_tag[CTAG_BITS-1:0];

  always_comb begin
    w_inc = '0;
    w_dec = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_inc[i] = w_accept & ~w_req.rw & w_grant[i];
      w_dec[i] = w_resp_last & (w_resp_id == ID_BITS'(i));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rbeat   <= '0;
      r_out_cnt <= '0;
    end else begin
      if (mem_bus.mem_resp_val) r_rbeat <= w_resp_last ? '0 : r_rbeat + RB_W'(1);
      for (int i = 0; i < N_REQ; i++) begin
        unique case ({w_inc[i], w_dec[i]})
          2'b10:   r_out_cnt[i] <= r_out_cnt[i] + CNT_W'(1);
          2'b01:   r_out_cnt[i] <= r_out_cnt[i] - CNT_W'(1);
          default: r_out_cnt[i] <= r_out_cnt[i];
        endcase
      end
    end
  end

  for (genvar g = 0; g < N_REQ; g++) begin : g_cnt_chk
    a_no_underflow: assert property (@(posedge clk) disable iff (!reset)
      !(w_dec[g] && !w_inc[g] && (r_out_cnt[g] == '0)));
    a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
      !(w_inc[g] && !w_dec[g] && (r_out_cnt[g] == CNT_W'(MAX_OUT))));
  end

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Directed bench for riscv_mem_arbiter: alternation, write lock, read credit,
// response routing, memory stall and mid-burst reset.
module tb_riscv_mem_arbiter;
  import riscv_mem_arbiter_pkg::*;

  typedef logic [127:0] v_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  riscv_mem_arbiter_if     req_bus ();
  riscv_mem_arbiter_mem_if mem_bus ();

  riscv_mem_arbiter dut (
    .clk     (clk),
    .reset   (reset),
    .req_bus (req_bus),
    .mem_bus (mem_bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input v_t obs, input v_t exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    req_bus.req_val  = '0;
    req_bus.req_rw   = '0;
    req_bus.req_addr = '0;
    req_bus.req_data = '0;
    req_bus.req_tag  = '0;
    mem_bus.mem_req_rdy   = 1'b1;
    mem_bus.mem_resp_val  = 1'b0;
    mem_bus.mem_resp_data = '0;
    mem_bus.mem_resp_tag  = '0;

    // Reset with live inputs: every output held low.
    req_bus.req_val      = 2'b11;
    mem_bus.mem_resp_val = 1'b1;
    step();
    settle();
    check("rst_req_rdy",  v_t'(req_bus.req_rdy),      v_t'(2'b00));
    check("rst_resp_val", v_t'(req_bus.resp_val),     v_t'(2'b00));
    check("rst_mem_val",  v_t'(mem_bus.mem_req_val),  v_t'(1'b0));
    mem_bus.mem_resp_val = 1'b0;
    req_bus.req_val      = '0;
    step();
    reset = 1'b1;

    // Both requesters stream reads: grants alternate starting at 0.
    req_bus.req_addr[0] = 26'h100;
    req_bus.req_addr[1] = 26'h200;
    req_bus.req_tag[0]  = 5'h01;
    req_bus.req_tag[1]  = 5'h02;
    req_bus.req_val     = 2'b11;
    req_bus.req_rw      = 2'b00;
    for (int k = 0; k < 4; k++) begin
      settle();
      check("alt_rdy", v_t'(req_bus.req_rdy),     (k % 2 == 0) ? v_t'(2'b01) : v_t'(2'b10));
      check("alt_tag", v_t'(mem_bus.mem_req_tag), (k % 2 == 0) ? v_t'(6'h01) : v_t'(6'h22));
      step();
    end

    // Req1 two-beat write against req0 reads; lock holds through a read hiccup.
    req_bus.req_rw      = 2'b10;
    req_bus.req_addr[1] = 26'h40;
    req_bus.req_data[1] = 128'hA0;
    settle();
    check("wr_pre_rdy", v_t'(req_bus.req_rdy), v_t'(2'b01));
    step();
    settle();
    check("wr_b0_rdy",  v_t'(req_bus.req_rdy),      v_t'(2'b10));
    check("wr_b0_rw",   v_t'(mem_bus.mem_req_rw),   v_t'(1'b1));
    check("wr_b0_addr", v_t'(mem_bus.mem_req_addr), v_t'(26'h40));
    check("wr_b0_data", v_t'(mem_bus.mem_req_data), v_t'(128'hA0));
    step();
    req_bus.req_rw = 2'b00;
    settle();
    check("wr_lock_rd_rdy", v_t'(req_bus.req_rdy),     v_t'(2'b00));
    check("wr_lock_rd_val", v_t'(mem_bus.mem_req_val), v_t'(1'b0));
    step();
    req_bus.req_rw      = 2'b10;
    req_bus.req_data[1] = 128'hA1;
    settle();
    check("wr_b1_rdy",  v_t'(req_bus.req_rdy),      v_t'(2'b10));
    check("wr_b1_data", v_t'(mem_bus.mem_req_data), v_t'(128'hA1));
    step();
    req_bus.req_val = 2'b01;
    req_bus.req_rw  = 2'b00;
    settle();
    check("wr_post_rdy", v_t'(req_bus.req_rdy), v_t'(2'b01));
    step();
    req_bus.req_val = '0;
    pulse_reset();

    // Read credit: eight reads pass, the ninth is held, req1 still passes.
    req_bus.req_tag[0] = 5'h07;
    req_bus.req_val    = 2'b01;
    for (int k = 0; k < 8; k++) begin
      settle();
      check("cred_rd_rdy", v_t'(req_bus.req_rdy), v_t'(2'b01));
      step();
    end
    settle();
    check("cred_full_rdy", v_t'(req_bus.req_rdy),     v_t'(2'b00));
    check("cred_full_val", v_t'(mem_bus.mem_req_val), v_t'(1'b0));
    check("cred_cnt0",     v_t'(dut.r_out_cnt[0]),    v_t'(4'd8));
    req_bus.req_val = 2'b11;
    settle();
    check("cred_req1_rdy", v_t'(req_bus.req_rdy), v_t'(2'b10));
    step();
    req_bus.req_val       = 2'b01;
    mem_bus.mem_resp_val  = 1'b1;
    mem_bus.mem_resp_tag  = 6'h07;
    mem_bus.mem_resp_data = 128'hD0;
    settle();
    check("cred_b0_resp", v_t'(req_bus.resp_val), v_t'(2'b01));
    check("cred_b0_rdy",  v_t'(req_bus.req_rdy),  v_t'(2'b00));
    step();
    mem_bus.mem_resp_data = 128'hD1;
    settle();
    check("cred_b1_resp", v_t'(req_bus.resp_val), v_t'(2'b01));
    check("cred_b1_rdy",  v_t'(req_bus.req_rdy),  v_t'(2'b00));
    step();
    mem_bus.mem_resp_val = 1'b0;
    settle();
    check("cred_reelig_rdy", v_t'(req_bus.req_rdy), v_t'(2'b01));
    step();
    req_bus.req_val = '0;
    check("cred_cnt0_refill", v_t'(dut.r_out_cnt[0]), v_t'(4'd8));

    // Response to requester 1, tag 5'h13: routed on both beats, credit back after beat 1.
    mem_bus.mem_resp_val  = 1'b1;
    mem_bus.mem_resp_tag  = 6'h33;
    mem_bus.mem_resp_data = 128'hBEEF0;
    settle();
    check("r1_b0_val",  v_t'(req_bus.resp_val),  v_t'(2'b10));
    check("r1_b0_tag",  v_t'(req_bus.resp_tag),  v_t'(5'h13));
    check("r1_b0_data", v_t'(req_bus.resp_data), v_t'(128'hBEEF0));
    step();
    check("r1_b0_cnt1", v_t'(dut.r_out_cnt[1]), v_t'(4'd1));
    mem_bus.mem_resp_data = 128'hBEEF1;
    settle();
    check("r1_b1_val",  v_t'(req_bus.resp_val),  v_t'(2'b10));
    check("r1_b1_tag",  v_t'(req_bus.resp_tag),  v_t'(5'h13));
    check("r1_b1_data", v_t'(req_bus.resp_data), v_t'(128'hBEEF1));
    step();
    mem_bus.mem_resp_val = 1'b0;
    check("r1_b1_cnt1", v_t'(dut.r_out_cnt[1]), v_t'(4'd0));

    // Read accept and final response beat for req1 in one cycle: count holds.
    req_bus.req_val = 2'b10;
    settle();
    check("sim_pre_rdy", v_t'(req_bus.req_rdy), v_t'(2'b10));
    step();
    req_bus.req_val      = 2'b00;
    mem_bus.mem_resp_val = 1'b1;
    mem_bus.mem_resp_tag = 6'h20;
    step();
    req_bus.req_val = 2'b10;
    settle();
    check("sim_rdy", v_t'(req_bus.req_rdy), v_t'(2'b10));
    step();
    mem_bus.mem_resp_val = 1'b0;
    req_bus.req_val      = 2'b00;
    check("sim_cnt1", v_t'(dut.r_out_cnt[1]), v_t'(4'd1));
    pulse_reset();

    // Memory stall: grant parked on 0, nothing accepted, pointer unchanged.
    req_bus.req_val     = 2'b11;
    req_bus.req_rw      = 2'b00;
    mem_bus.mem_req_rdy = 1'b0;
    for (int k = 0; k < 5; k++) begin
      settle();
      check("stall_rdy", v_t'(req_bus.req_rdy),                   v_t'(2'b00));
      check("stall_val", v_t'(mem_bus.mem_req_val),               v_t'(1'b1));
      check("stall_gnt", v_t'(mem_bus.mem_req_tag[MEM_TAG_BITS-1]), v_t'(1'b0));
      step();
    end
    mem_bus.mem_req_rdy = 1'b1;
    settle();
    check("stall_rel0", v_t'(req_bus.req_rdy), v_t'(2'b01));
    step();
    settle();
    check("stall_rel1", v_t'(req_bus.req_rdy), v_t'(2'b10));
    step();

    // Stall inside a locked burst keeps the lock and the owner.
    req_bus.req_rw = 2'b10;
    settle();
    check("lstall_pre", v_t'(req_bus.req_rdy), v_t'(2'b01));
    step();
    settle();
    check("lstall_b0", v_t'(req_bus.req_rdy), v_t'(2'b10));
    step();
    mem_bus.mem_req_rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      settle();
      check("lstall_rdy", v_t'(req_bus.req_rdy),                     v_t'(2'b00));
      check("lstall_gnt", v_t'(mem_bus.mem_req_tag[MEM_TAG_BITS-1]), v_t'(1'b1));
      check("lstall_rw",  v_t'(mem_bus.mem_req_rw),                  v_t'(1'b1));
      step();
    end
    mem_bus.mem_req_rdy = 1'b1;
    settle();
    check("lstall_b1", v_t'(req_bus.req_rdy), v_t'(2'b10));
    step();
    settle();
    check("lstall_post", v_t'(req_bus.req_rdy), v_t'(2'b01));
    step();

    // Reset right after write beat 0 discards the lock and credits.
    settle();
    check("mrst_b0", v_t'(req_bus.req_rdy), v_t'(2'b10));
    step();
    reset                = 1'b0;
    mem_bus.mem_resp_val = 1'b1;
    mem_bus.mem_resp_tag = 6'h00;
    settle();
    check("mrst_req_rdy",  v_t'(req_bus.req_rdy),     v_t'(2'b00));
    check("mrst_resp_val", v_t'(req_bus.resp_val),    v_t'(2'b00));
    check("mrst_mem_val",  v_t'(mem_bus.mem_req_val), v_t'(1'b0));
    step();
    mem_bus.mem_resp_val = 1'b0;
    check("mrst_cnt0", v_t'(dut.r_out_cnt[0]), v_t'(4'd0));
    check("mrst_cnt1", v_t'(dut.r_out_cnt[1]), v_t'(4'd0));
    reset          = 1'b1;
    req_bus.req_rw = 2'b00;
    settle();
    check("mrst_first_gnt", v_t'(req_bus.req_rdy), v_t'(2'b01));
    step();
    req_bus.req_val = '0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/riscv_mem_arbiter.md
Name: riscv_mem_arbiter

Overview:
- Shares the single DRAM memory port (the core-side mem_req/mem_resp interface of the DRAM adapter) between N_REQ requesters (port 0 = icache refill, port 1 = dcache/HTIF).
- Round-robin arbitration with a write-burst lock and per-requester outstanding-read limits.
- Requester ID is prepended to the tag so responses route back combinationally.
- Sits between the cache refill units and the DRAM adapter.

Parameters:
- N_REQ, 2, number of requesters (power of two, 2..4)
- ID_BITS, $clog2(N_REQ), requester-ID field width in the memory tag
- CTAG_BITS, `MEM_TAG_BITS-ID_BITS, client tag width
- WR_BEATS, 2, request beats per write transaction
- RD_BEATS, 2, response beats per read transaction
- MAX_OUT, 8, maximum outstanding reads per requester

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- req_val  in  N_REQ  per-requester request valid
- req_rdy  out  N_REQ  per-requester request ready
- req_rw  in  N_REQ  1 = write, 0 = read
- req_addr  in  N_REQ x `MEM_ADDR_BITS  request address
- req_data  in  N_REQ x `MEM_DATA_BITS  write data beat
- req_tag  in  N_REQ x CTAG_BITS  client tag
- resp_val  out  N_REQ  per-requester response valid
- resp_data  out  `MEM_DATA_BITS  response data, shared
- resp_tag  out  CTAG_BITS  client tag, shared
- mem_req_val  out  1  to DRAM adapter
- mem_req_rdy  in  1  from DRAM adapter
- mem_req_rw  out  1
- mem_req_addr  out  `MEM_ADDR_BITS
- mem_req_data  out  `MEM_DATA_BITS
- mem_req_tag  out  `MEM_TAG_BITS  {id, client tag}
- mem_resp_val  in  1
- mem_resp_data  in  `MEM_DATA_BITS
- mem_resp_tag  in  `MEM_TAG_BITS

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-low. While reset=0: rr_ptr=0, lock clear, beat counters=0, all outstanding counters=0, and every output is forced low (req_rdy, resp_val, mem_req_val).
- Eligibility: requester i is eligible when req_val[i] and (req_rw[i] or out_cnt[i] < MAX_OUT).
- Unlocked grant: combinational. Pick the first eligible requester searching from rr_ptr upward, with wrap.
- Locked grant: grant = lock_id only. If lock_id presents rw=0 while locked, it is not granted and the arbiter stalls.
- Request mux: mem_req_val = granted requester's val. mem_req_* = granted requester's fields. mem_req_tag = {grant_id, req_tag[grant_id]}.
- Ready: req_rdy[i] = (grant_id==i) & mem_req_rdy. Zero-cycle latency; no request buffering.
- Accept = mem_req_val & mem_req_rdy.
- Write lock:
  - On accept of write beat 0 with WR_BEATS>1: set lock, lock_id=grant_id, wbeat=1.
  - Each further accepted beat increments wbeat.
  - On the beat with wbeat==WR_BEATS-1: clear lock, wbeat=0.
- rr_ptr update: rr_ptr <= grant_id+1 (mod N_REQ) on accept of a read, or of the final write beat. Unchanged otherwise.
- Outstanding counters:
  - out_cnt[i]++ on accepted read from i.
  - out_cnt[i]-- on the final response beat routed to i.
  - Both events in the same cycle: counter unchanged.
  - Never exceeds MAX_OUT; underflow is an assertion failure.
- Response routing:
  - resp_val[i] = mem_resp_val & (mem_resp_tag[MSBs]==i).
  - resp_data and resp_tag (the low CTAG_BITS) are broadcast to all requesters.
  - Responses are in order and non-interleaved. rbeat counts 0..RD_BEATS-1 on mem_resp_val and wraps to 0 on the final beat.
  - No backpressure on responses: requesters must sink a beat every cycle it is valid.
- Simultaneous events: a request accept and a response beat in the same cycle are independent and both processed.
- Reset mid-burst: lock, counters and in-flight accounting are discarded. Reset is system-wide; the memory side is reset concurrently.

Decomposition:
- Shared package mem_arb_pkg holds: ID_BITS and CTAG_BITS derivation, typedef mem_req_t {rw, addr, data, tag}, and the RD_BEATS/WR_BEATS defaults.
- One sub-module, rr_arbiter: N-way round-robin priority picker taking req[N], ptr and lock/lock_id, and producing a one-hot grant plus grant_id.

Test Plan:
- Req0 and req1 both issue continuous reads, mem_req_rdy=1 → grants alternate 0,1,0,1. mem_req_tag MSB matches. Each req_rdy is high every other cycle.
- Req1 issues a 2-beat write (addr 0x40) while req0 reads → beats 0 and 1 of req1 are back-to-back, req0 is stalled in between, and req0 is granted next.
- Req0 issues 8 reads with responses withheld → the 9th read sees req_rdy[0]=0 while req1 reads still pass. One 2-beat response to tag {0,x} → req0 becomes eligible again.
- Memory returns a 2-beat response with tag {1,5'h13} → resp_val=2'b10 on both beats, resp_tag=5'h13, resp_data matches each beat, and out_cnt[1] decrements after beat 1 only.
- mem_req_rdy=0 for 5 cycles with both requesters valid → no accept, rr_ptr and lock unchanged, grant stable, req_rdy=0.
- Reset pulsed low after write beat 0 → all outputs 0 during reset. After release: lock clear, out_cnt=0, grant starts at requester 0.
